// File: rtl/score_digit_writer.sv
// Renders a saturated 4-digit decimal score into a 1-bit overlay RAM by copying glyphs from the numbers ROM.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (the ones digit is always drawn).
module score_digit_writer #(
    parameter int SCORE_W    = 14,
    parameter int GLYPH_W    = 10,
    parameter int GLYPH_H    = 14,
    parameter int ROM_W      = 100,
    parameter int NUM_DIGITS = 4
) (
    input  logic               vga_clk,
    input  logic               reset,
    input  logic               start,
    input  logic [SCORE_W-1:0] score,
    output logic               busy,
    output logic               done,
    output logic [10:0]        rom_address,
    input  logic               rom_q,
    output logic [9:0]         wr_addr,
    output logic               wr_data,
    output logic               wr_en
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int OV_W  = NUM_DIGITS * GLYPH_W;
    localparam int POS_W = $clog2(NUM_DIGITS);
    localparam int ROW_W = $clog2(GLYPH_H);
    localparam int COL_W = $clog2(GLYPH_W);
    localparam int CNV_W = $clog2(SCORE_W);
    localparam logic [SCORE_W-1:0] MAX_SCORE = SCORE_W'(9999);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CONVERT = 3'd1,
        COPY    = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [SCORE_W-1:0] bin_r;
    logic [BCD_W-1:0]   bcd_r;
    logic [BCD_W-1:0]   bcd_step_s;
    logic [CNV_W-1:0]   cnv_cnt_r;
    logic [POS_W-1:0]   pos_r;
    logic [ROW_W-1:0]   row_r;
    logic [COL_W-1:0]   col_r;
    logic [POS_W-1:0]   pos_nxt_s;
    logic [ROW_W-1:0]   row_nxt_s;
    logic [COL_W-1:0]   col_nxt_s;
    logic               cnv_last_s;
    logic               copy_last_s;
    logic               blank_r;

    // One double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit.
    function automatic logic [BCD_W-1:0] dabble_f(input logic [BCD_W-1:0] bcd, input logic bit_in);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = adj[4*i +: 4];
            end
        end
        return {adj[BCD_W-2:0], bit_in};
    endfunction

    // Position 0 is the most significant nibble.
    function automatic logic [3:0] digit_f(input logic [BCD_W-1:0] bcd, input logic [POS_W-1:0] pos);
        logic [3:0] d;
        d = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (int'(pos) == i) begin
                d = bcd[4*(NUM_DIGITS-1-i) +: 4];
            end else begin
                d = d;
            end
        end
        return d;
    endfunction

    function automatic logic [10:0] rom_addr_f(input logic [3:0] digit, input logic [ROW_W-1:0] row,
                                               input logic [COL_W-1:0] col);
        return 11'(row) * 11'(ROM_W) + 11'(digit) * 11'(GLYPH_W) + 11'(col);
    endfunction

    function automatic logic [9:0] ov_addr_f(input logic [POS_W-1:0] pos, input logic [ROW_W-1:0] row,
                                             input logic [COL_W-1:0] col);
        return 10'(row) * 10'(OV_W) + 10'(pos) * 10'(GLYPH_W) + 10'(col);
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // A position is blank when it and every position to its left hold zero; the last one never is.
    function automatic logic blank_f(input logic [BCD_W-1:0] bcd, input logic [POS_W-1:0] pos);
        logic lead;
        lead = 1'b1;
        for (int i = 0; i < NUM_DIGITS - 1; i++) begin
            if (i <= int'(pos) && digit_f(bcd, POS_W'(i)) != 4'd0) begin
                lead = 1'b0;
            end else begin
                lead = lead;
            end
        end
        return lead && (int'(pos) != NUM_DIGITS - 1);
    endfunction
`endif

    assign bcd_step_s  = dabble_f(bcd_r, bin_r[SCORE_W-1]);
    assign cnv_last_s  = (cnv_cnt_r == CNV_W'(SCORE_W - 1));
    assign copy_last_s = (pos_r == POS_W'(NUM_DIGITS - 1)) && (row_r == ROW_W'(GLYPH_H - 1)) &&
                         (col_r == COL_W'(GLYPH_W - 1));
    assign wr_data     = rom_q & ~blank_r;

    // Copy-loop counter successor: col innermost, then row, then pos.
    always_comb begin
        col_nxt_s = col_r + COL_W'(1);
        row_nxt_s = row_r;
        pos_nxt_s = pos_r;
        if (col_r == COL_W'(GLYPH_W - 1)) begin
            col_nxt_s = COL_W'(0);
            if (row_r == ROW_W'(GLYPH_H - 1)) begin
                row_nxt_s = ROW_W'(0);
                pos_nxt_s = pos_r + POS_W'(1);
            end else begin
                row_nxt_s = row_r + ROW_W'(1);
            end
        end else begin
            col_nxt_s = col_r + COL_W'(1);
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = CONVERT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CONVERT: begin
                if (cnv_last_s) begin
                    state_nxt_s = COPY;
                end else begin
                    state_nxt_s = CONVERT;
                end
            end
            COPY: begin
                if (copy_last_s) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = COPY;
                end
            end
            DRAIN:   state_nxt_s = DONE;
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath: conversion, ROM address issue and the one-cycle write pipeline.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= 10'd0;
            rom_address <= 11'd0;
            bin_r       <= '0;
            bcd_r       <= '0;
            cnv_cnt_r   <= '0;
            pos_r       <= '0;
            row_r       <= '0;
            col_r       <= '0;
            blank_r     <= 1'b0;
        end else begin
            wr_en <= (state_r == COPY);
            done  <= (state_r == DRAIN);
            if (state_r == COPY) begin
                wr_addr <= ov_addr_f(pos_r, row_r, col_r);
`ifdef LEADING_ZERO_BLANK_EN
                blank_r <= blank_f(bcd_r, pos_r);
`else
                blank_r <= 1'b0;
`endif
            end
            case (state_r)
                IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        bin_r     <= (score > MAX_SCORE) ? MAX_SCORE : score;
                        bcd_r     <= '0;
                        cnv_cnt_r <= '0;
                    end
                end
                CONVERT: begin
                    bcd_r     <= bcd_step_s;
                    bin_r     <= {bin_r[SCORE_W-2:0], 1'b0};
                    cnv_cnt_r <= cnv_cnt_r + CNV_W'(1);
                    // The last step's result feeds the first address directly.
                    if (cnv_last_s) begin
                        pos_r       <= '0;
                        row_r       <= '0;
                        col_r       <= '0;
                        rom_address <= rom_addr_f(digit_f(bcd_step_s, POS_W'(0)), ROW_W'(0), COL_W'(0));
                    end
                end
                COPY: begin
                    if (!copy_last_s) begin
                        pos_r       <= pos_nxt_s;
                        row_r       <= row_nxt_s;
                        col_r       <= col_nxt_s;
                        rom_address <= rom_addr_f(digit_f(bcd_r, pos_nxt_s), row_nxt_s, col_nxt_s);
                    end
                end
                DRAIN: begin
                    busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
